axis_uart_tx_frame: RTL and testbench

//  AXI-Stream to UART serializer. Each accepted AXIS word is split into NUM_CHARS = AXI_DATA_WIDTH/DATA_BITS characters.

---
 rtl/axis_uart_tx_frame.sv | 183 ++++++++++++++++++
 tb/tb_axis_uart_tx_frame.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/axis_uart_tx_frame.sv
// AXI-Stream word to UART serializer: one asynchronous frame per kept lane,
// with selectable parity, stop bits, lane order and a runtime baud divisor.
module axis_uart_tx_frame #(
   parameter int unsigned AXI_DATA_WIDTH = 32,
   parameter int unsigned CLOCK          = 100_000_000,
   parameter int unsigned BAUD_RATE      = 115_200,
   parameter int unsigned DATA_BITS      = 8,
   parameter int unsigned STOP_BITS      = 1,
   parameter int unsigned PARITY_MODE    = 0,
   parameter bit          MSB_LANE_FIRST = 1'b1,
   parameter int unsigned DIV_W          = 16,
   localparam int unsigned NUM_CHARS     = AXI_DATA_WIDTH / DATA_BITS
) (
   input  logic                      aclk,
   input  logic                      aresetn,
   input  logic [AXI_DATA_WIDTH-1:0] s_axis_tdata,
   input  logic [NUM_CHARS-1:0]      s_axis_tkeep,
   input  logic                      s_axis_tvalid,
   output logic                      s_axis_tready,
   input  logic [DIV_W-1:0]          baud_div,
   output logic                      uart_tx,
   output logic                      busy,
   output logic                      tx_done
);

   localparam int unsigned     LANE_W     = (NUM_CHARS > 1) ? $clog2(NUM_CHARS) : 1;
   localparam logic [DIV_W-1:0] DEF_DIV   = DIV_W'(CLOCK / BAUD_RATE);
   localparam bit              HAS_PARITY = (PARITY_MODE != 0);
   localparam logic [3:0]      LAST_DATA  = 4'(DATA_BITS - 1);
   localparam logic [3:0]      LAST_STOP  = 4'(STOP_BITS - 1);

   generate
      if (AXI_DATA_WIDTH % DATA_BITS != 0) begin : g_bad_width
         $error("AXI_DATA_WIDTH must be a multiple of DATA_BITS");
      end
      if (CLOCK / BAUD_RATE < 2) begin : g_bad_div
         $error("CLOCK/BAUD_RATE must be at least 2");
      end
      if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_bits
         $error("DATA_BITS must be 5..9");
      end
      if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
         $error("STOP_BITS must be 1 or 2");
      end
      if (PARITY_MODE > 2) begin : g_bad_parity
         $error("PARITY_MODE must be 0, 1 or 2");
      end
   endgenerate

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

   state_t                    state;
   logic [AXI_DATA_WIDTH-1:0] word_q;
   logic [NUM_CHARS-1:0]      pend_q;
   logic [DIV_W-1:0]          div_q;
   logic [DIV_W-1:0]          cnt_q;
   logic [3:0]                bit_q;
   logic [DATA_BITS-1:0]      sh_q;
   logic                      par_q;
   logic                      rst_done;

   logic [NUM_CHARS-1:0]      src_keep;
   logic [AXI_DATA_WIDTH-1:0] src_data;
   logic [LANE_W-1:0]         sel;
   logic                      any_pend;
   logic [DATA_BITS-1:0]      sel_char;
   logic                      sel_par;
   logic [NUM_CHARS-1:0]      rest_keep;
   logic [DIV_W-1:0]          acc_div;
   logic                      bit_end;

   // Lane picker is shared between word accept (live inputs) and the
   // end of each stop bit (latched remaining-lane mask).
   always_comb begin
      src_keep = (state == IDLE) ? s_axis_tkeep : pend_q;
      src_data = (state == IDLE) ? s_axis_tdata : word_q;
      sel      = '0;
      any_pend = 1'b0;
      for (int unsigned i = 0; i < NUM_CHARS; i++) begin
         if (src_keep[i] && (MSB_LANE_FIRST || !any_pend)) sel = LANE_W'(i);
         if (src_keep[i]) any_pend = 1'b1;
      end
      sel_char  = src_data[sel*DATA_BITS +: DATA_BITS];
      sel_par   = (^sel_char) ^ (PARITY_MODE == 2);
      rest_keep = src_keep & ~(NUM_CHARS'(1) << sel);
      acc_div   = (baud_div < DIV_W'(2)) ? DEF_DIV : baud_div;
      bit_end   = (cnt_q == div_q - 1'b1);
   end

   assign s_axis_tready = (state == IDLE) && rst_done;

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state    <= IDLE;
         word_q   <= '0;
         pend_q   <= '0;
         div_q    <= '0;
         cnt_q    <= '0;
         bit_q    <= '0;
         sh_q     <= '0;
         par_q    <= 1'b0;
         rst_done <= 1'b0;
         uart_tx  <= 1'b1;
         busy     <= 1'b0;
         tx_done  <= 1'b0;
      end else begin
         rst_done <= 1'b1;
         tx_done  <= 1'b0;
         if (state == IDLE) begin
            if (s_axis_tvalid && rst_done) begin
               word_q <= s_axis_tdata;
               div_q  <= acc_div;
               cnt_q  <= '0;
               bit_q  <= '0;
               if (any_pend) begin
                  state   <= START;
                  busy    <= 1'b1;
                  uart_tx <= 1'b0;
                  sh_q    <= sel_char;
                  par_q   <= sel_par;
                  pend_q  <= rest_keep;
               end else begin
                  tx_done <= 1'b1;
               end
            end
         end else begin
            cnt_q <= bit_end ? '0 : cnt_q + 1'b1;
            if (bit_end) begin
               case (state)
                  START: begin
                     state   <= DATA;
                     uart_tx <= sh_q[0];
                  end
                  DATA: begin
                     if (bit_q == LAST_DATA) begin
                        bit_q <= '0;
                        if (HAS_PARITY) begin
                           state   <= PARITY;
                           uart_tx <= par_q;
                        end else begin
                           state   <= STOP;
                           uart_tx <= 1'b1;
                        end
                     end else begin
                        bit_q   <= bit_q + 1'b1;
                        sh_q    <= sh_q >> 1;
                        uart_tx <= sh_q[1];
                     end
                  end
                  PARITY: begin
                     state   <= STOP;
                     uart_tx <= 1'b1;
                  end
                  STOP: begin
                     if (bit_q == LAST_STOP) begin
                        bit_q <= '0;
                        if (any_pend) begin
                           state   <= START;
                           uart_tx <= 1'b0;
                           sh_q    <= sel_char;
                           par_q   <= sel_par;
                           pend_q  <= rest_keep;
                        end else begin
                           state   <= IDLE;
                           busy    <= 1'b0;
                           tx_done <= 1'b1;
                           uart_tx <= 1'b1;
                        end
                     end else begin
                        bit_q <= bit_q + 1'b1;
                     end
                  end
                  default: begin
                     state   <= IDLE;
                     uart_tx <= 1'b1;
                  end
               endcase
            end
         end
      end
   end

endmodule

// File: tb/tb_axis_uart_tx_frame.sv
// Randomized scoreboard bench for axis_uart_tx_frame over three line formats
// (8N1 MSB-lane-first, 8E2 lane-0-first, 8O1 MSB-lane-first), DEF_DIV = 10.
module tb_axis_uart_tx_frame;

   localparam int unsigned NCFG = 3;

   typedef struct {
      int unsigned start;
      logic [7:0]  ch;
      int unsigned div;
   } frm_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int unsigned n_chk  = 0;
   int unsigned n_fail = 0;
   bit          fin[NCFG];

   task automatic chk(input string nm, input int g, input longint a, input longint e);
      n_chk++;
      if (a != e) begin
         n_fail++;
         $display("FAIL %s cfg%0d cyc %0d: got %0h expected %0h", nm, g, cyc, a, e);
      end
   endtask

   for (genvar g = 0; g < NCFG; g++) begin : g_cfg
      localparam int unsigned PAR   = g;
      localparam int unsigned STOPB = (g == 1) ? 2 : 1;
      localparam bit          MSBF  = (g != 1);
      localparam int unsigned FL    = 1 + 8 + ((PAR != 0) ? 1 : 0) + STOPB;

      logic        rst_n = 1'b0;
      logic        tvalid, tready, tx, busy, done;
      logic [31:0] tdata;
      logic [3:0]  tkeep;
      logic [15:0] bdiv;
      frm_t        fq[$];
      int unsigned dq[$];

      axis_uart_tx_frame #(
         .AXI_DATA_WIDTH(32),
         .CLOCK(1000),
         .BAUD_RATE(100),
         .DATA_BITS(8),
         .STOP_BITS(STOPB),
         .PARITY_MODE(PAR),
         .MSB_LANE_FIRST(MSBF),
         .DIV_W(16)
      ) dut (
         .aclk(clk),
         .aresetn(rst_n),
         .s_axis_tdata(tdata),
         .s_axis_tkeep(tkeep),
         .s_axis_tvalid(tvalid),
         .s_axis_tready(tready),
         .baud_div(bdiv),
         .uart_tx(tx),
         .busy(busy),
         .tx_done(done)
      );

      // Monitor: decodes the line frame by frame and pops the scoreboard.
      logic        prev_tx = 1'b1;
      bit          act     = 1'b0;
      frm_t        cur;
      int unsigned pos     = 0;
      bit          glitch  = 1'b0;
      logic [11:0] ebits, rbits;

      always @(negedge clk) begin
         if (!rst_n) begin
            act     = 1'b0;
            prev_tx = 1'b1;
         end else begin
            if (!act && prev_tx && !tx) begin
               chk("frame_expected", g, fq.size() > 0, 1);
               if (fq.size() > 0) begin
                  cur = fq.pop_front();
                  chk("frame_start_cycle", g, cyc, cur.start);
                  ebits      = '1;
                  ebits[0]   = 1'b0;
                  ebits[8:1] = cur.ch;
                  if (PAR == 1) ebits[9] = ^cur.ch;
                  if (PAR == 2) ebits[9] = ~^cur.ch;
                  rbits  = '1;
                  act    = 1'b1;
                  pos    = 0;
                  glitch = 1'b0;
               end
            end
            if (act) begin
               if (tx !== ebits[pos / cur.div]) glitch = 1'b1;
               if (pos % cur.div == cur.div / 2) rbits[pos / cur.div] = tx;
               pos++;
               if (pos == FL * cur.div) begin
                  act = 1'b0;
                  chk("frame_bits", g, rbits, ebits);
                  chk("frame_steady", g, glitch, 0);
               end
            end
            prev_tx = tx;
            if (done) begin
               chk("done_expected", g, dq.size() > 0, 1);
               if (dq.size() > 0) chk("done_cycle", g, cyc, dq.pop_front());
               chk("idle_busy", g, busy, 0);
               chk("idle_tready", g, tready, 1);
               chk("idle_line", g, tx, 1);
            end
         end
      end

      // Called at a negedge; returns at the negedge after the accept edge.
      task automatic send(input logic [31:0] w, input logic [3:0] k, input logic [15:0] bd);
         int unsigned guard = 0;
         int unsigned t, dv;
         int          lane;
         tvalid = 1'b1;
         while (!tready && guard < 3000) begin
            tdata = $urandom;
            tkeep = 4'($urandom);
            bdiv  = 16'($urandom_range(0, 30));
            @(negedge clk);
            guard++;
         end
         chk("tready_seen", g, tready, 1);
         if (!tready) begin
            tvalid = 1'b0;
            return;
         end
         tdata = w;
         tkeep = k;
         bdiv  = bd;
         dv    = (bd < 2) ? 10 : bd;
         t     = cyc + 1;
         for (int j = 0; j < 4; j++) begin
            lane = MSBF ? 3 - j : j;
            if (k[lane]) begin
               fq.push_back(frm_t'{t, w[lane*8 +: 8], dv});
               t += FL * dv;
            end
         end
         dq.push_back(t);
         @(negedge clk);
         tvalid = 1'b0;
         chk("busy_after_accept", g, busy, k != 0);
         chk("tready_after_accept", g, tready, k == 0);
      endtask

      initial begin
         int unsigned guard;
         tvalid = 1'b0;
         tdata  = '0;
         tkeep  = '0;
         bdiv   = '0;
         repeat (3) @(negedge clk);
         chk("rst_line", g, tx, 1);
         chk("rst_tready", g, tready, 0);
         chk("rst_busy", g, busy, 0);
         chk("rst_done", g, done, 0);
         rst_n = 1'b1;
         @(negedge clk);
         chk("ready_after_rst", g, tready, 1);

         send(32'hA5C3_0F81, 4'hF, 16'd0);
         send(32'hA5C3_0F81, 4'h5, 16'd0);
         send(32'hA5C3_0F81, 4'h0, 16'd1);
         send(32'h0000_0007, 4'h1, 16'd0);
         send(32'h0000_0000, 4'h1, 16'd1);
         send(32'h1234_5678, 4'hF, 16'd4);
         for (int n = 0; n < 30; n++) begin
            if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 5)) @(negedge clk);
            send($urandom, 4'($urandom), 16'($urandom_range(0, 6)));
         end

         // Abandon a word mid data bit; the line must rise without a clock edge.
         guard = 0;
         while ((fq.size() != 0 || dq.size() != 0) && guard < 5000) begin
            @(negedge clk);
            guard++;
         end
         send(32'h0000_0000, 4'hF, 16'd4);
         repeat (9) @(negedge clk);
         chk("line_low_before_reset", g, tx, 0);
         #2 rst_n = 1'b0;
         #1;
         chk("async_rst_line", g, tx, 1);
         chk("async_rst_tready", g, tready, 0);
         chk("async_rst_busy", g, busy, 0);
         fq.delete();
         dq.delete();
         repeat (3) @(negedge clk);
         rst_n = 1'b1;
         @(negedge clk);
         chk("rerst_tready", g, tready, 1);
         chk("rerst_busy", g, busy, 0);
         chk("rerst_line", g, tx, 1);
         repeat (60) @(negedge clk);
         send(32'hC300_0000, 4'h8, 16'd3);

         guard = 0;
         while ((fq.size() != 0 || dq.size() != 0) && guard < 5000) begin
            @(negedge clk);
            guard++;
         end
         chk("drain_frames", g, fq.size(), 0);
         chk("drain_done", g, dq.size(), 0);
         fin[g] = 1'b1;
      end
   end

   initial begin
      int unsigned guard = 0;
      while (!(fin[0] && fin[1] && fin[2]) && guard < 80000) begin
         @(negedge clk);
         guard++;
      end
      for (int i = 0; i < NCFG; i++) begin
         if (!fin[i]) chk("test_timeout", i, fin[i], 1);
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
